// File: rtl/hex_scroll_sched.sv
// hex_scroll_sched: message store, scroll position and refresh scheduler for one
// shared 7-segment decoder. Each scan presents four codes in turn on dec_code and
// latches the decoder's answer into the matching HEX digit register.
module hex_scroll_sched #(
    parameter int MSG_LEN  = 16,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] SW,
    input  logic       WR_EN,
    input  logic       RUN,
    input  logic       DIR,
    output logic [3:0] dec_code,
    input  logic [6:0] dec_seg,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       busy
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SET   = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    logic [3:0]    msg_r [MSG_LEN];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] base_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    state_r;
    logic [1:0]    slot_r;
    logic [AW-1:0] scan_base_r;
    logic          pending_r;
    logic [3:0]    dec_code_r;
    logic [6:0]    hex3_r;
    logic [6:0]    hex2_r;
    logic [6:0]    hex1_r;
    logic [6:0]    hex0_r;
    logic          busy_r;

    logic          tick_s;
    logic          last_slot_s;
    logic          start_s;
    logic [AW-1:0] rd_idx_s;

    assign dec_code = dec_code_r;
    assign HEX3     = hex3_r;
    assign HEX2     = hex2_r;
    assign HEX1     = hex1_r;
    assign HEX0     = hex0_r;
    assign busy     = busy_r;

    // Scroll tick, scan-start decision and buffer read index for the current slot.
    always_comb begin
        tick_s      = 1'b0;
        start_s     = 1'b0;
        last_slot_s = (slot_r == 2'd3);
        rd_idx_s    = scan_base_r + AW'(slot_r);
        if (RUN && (cnt_r == TICK_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        // A new scan starts from IDLE, or back-to-back after the last latch.
        if (pending_r && ((state_r == ST_IDLE) || ((state_r == ST_LATCH) && last_slot_s))) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Message buffer and write pointer; writes are never stalled by the scan.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_r[i] <= 4'hF;
            end
            wr_ptr_r <= '0;
        end else if (WR_EN) begin
            msg_r[wr_ptr_r] <= SW;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Prescaler (frozen while RUN=0) and scroll position, both wrapping naturally.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            cnt_r  <= '0;
            base_r <= '0;
        end else if (tick_s) begin
            cnt_r  <= '0;
            base_r <= DIR ? (base_r - AW'(1'b1)) : (base_r + AW'(1'b1));
        end else if (RUN) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Refresh request: a new request on the same edge as a scan start wins, so it is not lost.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            pending_r <= 1'b1;
        end else if (WR_EN || tick_s) begin
            pending_r <= 1'b1;
        end else if (start_s) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Scan sequencer: present a code, then latch the decoded segments into its digit.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            slot_r      <= 2'd0;
            scan_base_r <= '0;
            dec_code_r  <= 4'hF;
            hex3_r      <= 7'h7F;
            hex2_r      <= 7'h7F;
            hex1_r      <= 7'h7F;
            hex0_r      <= 7'h7F;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_SET;
                        slot_r      <= 2'd0;
                        scan_base_r <= base_r;
                        busy_r      <= 1'b1;
                    end
                end
                ST_SET: begin
                    dec_code_r <= msg_r[rd_idx_s];
                    state_r    <= ST_LATCH;
                end
                ST_LATCH: begin
                    case (slot_r)
                        2'd0:    hex3_r <= dec_seg;
                        2'd1:    hex2_r <= dec_seg;
                        2'd2:    hex1_r <= dec_seg;
                        2'd3:    hex0_r <= dec_seg;
                        default: hex0_r <= hex0_r;
                    endcase
                    if (!last_slot_s) begin
                        slot_r  <= slot_r + 2'd1;
                        state_r <= ST_SET;
                    end else if (start_s) begin
                        // Snapshot the current position so the next frame is consistent.
                        slot_r      <= 2'd0;
                        scan_base_r <= base_r;
                        state_r     <= ST_SET;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    slot_r  <= 2'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scroll_sched.sv
// Self-checking bench for hex_scroll_sched (MSG_LEN=16, TICK_DIV=4) with a
// behavioural model checked every cycle plus hand-computed display expectations.
module tb_hex_scroll_sched;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [3:0] SW;
    logic       WR_EN;
    logic       RUN;
    logic       DIR;
    logic [3:0] dec_code;
    logic [6:0] dec_seg;
    logic [6:0] HEX3, HEX2, HEX1, HEX0;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    // Active-low decoder, bit order {g,f,e,d,c,b,a}; code F is blank.
    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;  4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;  4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;  4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;  4'hE: seg_of = 7'h06;  default: seg_of = 7'h7F;
        endcase
    endfunction

    assign dec_seg = seg_of(dec_code);

    hex_scroll_sched #(.MSG_LEN(16), .TICK_DIV(4)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SW(SW), .WR_EN(WR_EN), .RUN(RUN), .DIR(DIR),
        .dec_code(dec_code), .dec_seg(dec_seg),
        .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0), .busy(busy)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase 0 = no scan; phase 1..8 = cycle within a scan, odd = code presented,
    // even = digit (phase-1)/2 takes the decoder's result.
    logic [3:0] m_msg [16];
    logic [6:0] m_hex [4];
    logic [3:0] m_dec;
    int m_wp, m_base, m_cnt, m_phase, m_sbase;
    bit m_pend, m_busy;

    task automatic model_step();
        int  k;
        bit  p_pend;
        bit  tick;
        if (!RESET_N) begin
            for (int i = 0; i < 16; i++) m_msg[i] = 4'hF;
            for (int i = 0; i < 4; i++) m_hex[i] = 7'h7F;
            m_dec = 4'hF; m_wp = 0; m_base = 0; m_cnt = 0;
            m_phase = 0; m_sbase = 0; m_pend = 1'b1; m_busy = 1'b0;
        end else begin
            p_pend = m_pend;
            tick   = RUN && (m_cnt == 3);
            k      = (m_phase - 1) / 2;
            if (m_phase == 0) begin
                if (p_pend) begin
                    m_phase = 1; m_sbase = m_base; m_busy = 1'b1; m_pend = 1'b0;
                end
            end else if (m_phase % 2 == 1) begin
                m_dec   = m_msg[(m_sbase + k) % 16];
                m_phase = m_phase + 1;
            end else begin
                m_hex[k] = seg_of(m_dec);
                if (m_phase < 8) m_phase = m_phase + 1;
                else if (p_pend) begin
                    m_phase = 1; m_sbase = m_base; m_pend = 1'b0;
                end else begin
                    m_phase = 0; m_busy = 1'b0;
                end
            end
            if (WR_EN) begin
                m_msg[m_wp] = SW; m_wp = (m_wp + 1) % 16; m_pend = 1'b1;
            end
            if (tick) begin
                m_cnt  = 0;
                m_base = DIR ? (m_base + 15) % 16 : (m_base + 1) % 16;
                m_pend = 1'b1;
            end else if (RUN) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    always @(posedge CLOCK_50) model_step();

    // Compare DUT against the model on every falling edge once reset has been applied.
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("cyc_HEX3", {1'b0, HEX3}, {1'b0, m_hex[0]});
            chk("cyc_HEX2", {1'b0, HEX2}, {1'b0, m_hex[1]});
            chk("cyc_HEX1", {1'b0, HEX1}, {1'b0, m_hex[2]});
            chk("cyc_HEX0", {1'b0, HEX0}, {1'b0, m_hex[3]});
            chk("cyc_busy", {7'd0, busy}, {7'd0, m_busy});
            chk("cyc_dec_code", {4'd0, dec_code}, {4'd0, m_dec});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, "_HEX3"}, {1'b0, HEX3}, {1'b0, e3});
        chk({tag, "_HEX2"}, {1'b0, HEX2}, {1'b0, e2});
        chk({tag, "_HEX1"}, {1'b0, HEX1}, {1'b0, e1});
        chk({tag, "_HEX0"}, {1'b0, HEX0}, {1'b0, e0});
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 2; i++) begin
            @(negedge CLOCK_50);
            if (!busy) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle_reached"}, (quiet >= 2) ? 8'd1 : 8'd0, 8'd1);
    endtask

    // Length of the next busy burst, measured in falling edges.
    task automatic busy_run(output int len);
        len = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (busy) break;
        end
        while (busy && len < 100) begin
            len++;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic pulse_wr(input logic [3:0] code);
        SW = code; WR_EN = 1'b1;
        @(negedge CLOCK_50);
        WR_EN = 1'b0;
    endtask

    int len;

    initial begin
        RESET_N = 1'b0; RUN = 1'b0; DIR = 1'b0; WR_EN = 1'b0; SW = 4'h0;
        @(posedge CLOCK_50);
        chk_en = 1'b1;
        @(negedge CLOCK_50);
        // Reset state.
        chk_hex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_dec_code", {4'd0, dec_code}, 8'h0F);
        RESET_N = 1'b1;
        busy_run(len);
        chk("first_scan_len", len[7:0], 8'd8);

        // Four writes while held.
        for (int i = 1; i <= 4; i++) pulse_wr(4'(i));
        wait_idle("wr");
        chk_hex("wr", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);

        // One left step: base 1.
        RUN = 1'b1; DIR = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        RUN = 1'b0;
        wait_idle("left");
        chk_hex("left", 7'b0100100, 7'b0110000, 7'b0011001, 7'b1111111);

        // Another left step (base 2) triggers a scan; write 5 into entry 4 during latch of slot 1.
        RUN = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        RUN = 1'b0;
        len = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (busy) break;
        end
        if (busy) len = 1;
        repeat (3) begin
            @(negedge CLOCK_50);
            if (busy) len++;
        end
        SW = 4'h5; WR_EN = 1'b1;
        @(negedge CLOCK_50);
        if (busy) len++;
        WR_EN = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (busy) len++;
            else break;
        end
        chk("rescan_busy_len", len[7:0], 8'd16);
        wait_idle("rescan");
        chk_hex("rescan", 7'b0110000, 7'b0011001, 7'b0010010, 7'b1111111);

        // Three right steps: base 2 -> 15, window wraps across the buffer end.
        RUN = 1'b1; DIR = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        RUN = 1'b0; DIR = 1'b0;
        wait_idle("right");
        chk_hex("right", 7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000);

        // Reset during slot 2 of a scan.
        pulse_wr(4'h7);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (busy) break;
        end
        repeat (4) @(negedge CLOCK_50);
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        chk_hex("midrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        RESET_N = 1'b1;
        busy_run(len);
        chk("midrst_scan_len", len[7:0], 8'd8);
        // Write pointer restarted at entry 0, shown on HEX3 with base 0.
        pulse_wr(4'h9);
        wait_idle("wrptr");
        chk_hex("wrptr", 7'b0010000, 7'h7F, 7'h7F, 7'h7F);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
